// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two valid/ready requesters share one write port.
// Optional busy-register scoreboard for decode hazards: RF_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic            RegWrite,
  output logic [4:0]      WriteRegister,
  output logic [XLEN-1:0] WriteData
);

  logic            prioB;
  logic            grantA;
  logic            grantB;
  logic            xfer;
  logic [4:0]      winRd;
  logic [XLEN-1:0] winData;
  logic            pendHazard;

  always_comb begin
    grantA  = a_valid && (!b_valid || (ARB_MODE == 1) || !prioB);
    grantB  = b_valid && !grantA;
    xfer    = grantA || grantB;
    winRd   = grantA ? a_rd : b_rd;
    winData = grantA ? a_data : b_data;
  end

  assign a_ready = grantA;
  assign b_ready = grantB;

  // prioB=1 means B wins the next contended cycle; only moves on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prioB <= 1'b0;
    end else if (xfer) begin
      prioB <= grantA;
    end
  end

  // Address/data follow every transfer; the enable is dropped for x0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= xfer && (winRd != '0);
      if (xfer) begin
        WriteRegister <= winRd;
        WriteData     <= winData;
      end
    end
  end

  always_comb begin
    pendHazard = RegWrite && (WriteRegister != '0) &&
                 ((WriteRegister == chk_rs1) || (WriteRegister == chk_rs2));
  end

`ifdef RF_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busyNext;

  // Clear applied before set so a same-edge issue to the same register stays busy.
  always_comb begin
    busyNext = busy;
    if (grantB) begin
      busyNext[b_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busyNext[iss_rd] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  always_comb begin
    hazard = pendHazard || busy[chk_rs1] || busy[chk_rs2];
  end
`else
  logic unusedIss;
  assign unusedIss = ^{iss_valid, iss_rd};

  always_comb begin
    hazard = pendHazard;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_rd, b_rd, iss_rd, chk_rs1, chk_rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, hazard, RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        p1ARdy, p1BRdy, p1Hazard, p1RegWrite;
  logic [4:0]  p1WriteRegister;
  logic [31:0] p1WriteData;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.ARB_MODE(0), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  regfile_wb_arbiter #(.ARB_MODE(1), .XLEN(32)) dutFixed (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(p1ARdy), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(p1BRdy), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(p1Hazard),
    .RegWrite(p1RegWrite), .WriteRegister(p1WriteRegister), .WriteData(p1WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aV;
    logic [4:0]  aRd;
    logic [31:0] aData;
    logic        bV;
    logic [4:0]  bRd;
    logic [31:0] bData;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        eARdy;
    logic        eBRdy;
    logic        eRW;
    logic [4:0]  eWR;
    logic [31:0] eWD;
    logic        eHz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0;
  endtask

  initial begin
    // Each row is one cycle: inputs driven, then readies and the registered
    // outputs (from the previous row's transfer) checked before the edge.
    vecs[0]  = '{0,0,32'h0,        0,0,32'h0,     0,0, 0,0,0,0,32'h0,        0};
    vecs[1]  = '{1,5,32'hDEADBEEF, 0,0,32'h0,     0,0, 1,0,0,0,32'h0,        0};
    vecs[2]  = '{0,0,32'h0,        0,0,32'h0,     0,0, 0,0,1,5,32'hDEADBEEF, 0};
    vecs[3]  = '{0,0,32'h0,        0,0,32'h0,     0,0, 0,0,0,5,32'hDEADBEEF, 0};
    vecs[4]  = '{1,7,32'h77,       0,0,32'h0,     0,0, 1,0,0,5,32'hDEADBEEF, 0};
    vecs[5]  = '{0,0,32'h0,        0,0,32'h0,     3,7, 0,0,1,7,32'h77,       1};
    vecs[6]  = '{0,0,32'h0,        0,0,32'h0,     3,7, 0,0,0,7,32'h77,       0};
    vecs[7]  = '{0,0,32'h0,        1,0,32'h1234,  0,0, 0,1,0,7,32'h77,       0};
    vecs[8]  = '{1,1,32'hA1,       1,2,32'hB2,    0,0, 1,0,0,0,32'h1234,     0};
    vecs[9]  = '{1,1,32'hA1,       1,2,32'hB2,    0,0, 0,1,1,1,32'hA1,       0};
    vecs[10] = '{1,1,32'hA1,       1,2,32'hB2,    0,0, 1,0,1,2,32'hB2,       0};
    vecs[11] = '{1,1,32'hA1,       1,2,32'hB2,    0,0, 0,1,1,1,32'hA1,       0};
    vecs[12] = '{0,0,32'h0,        0,0,32'h0,     2,0, 0,0,1,2,32'hB2,       1};
    vecs[13] = '{0,0,32'h0,        0,0,32'h0,     2,0, 0,0,0,2,32'hB2,       0};

    rst = 1'b0;
    idle();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset RegWrite", {31'b0, RegWrite}, 32'h0);
    check("reset WriteRegister", {27'b0, WriteRegister}, 32'h0);
    check("reset WriteData", WriteData, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a_valid = vecs[i].aV; a_rd = vecs[i].aRd; a_data = vecs[i].aData;
      b_valid = vecs[i].bV; b_rd = vecs[i].bRd; b_data = vecs[i].bData;
      chk_rs1 = vecs[i].rs1; chk_rs2 = vecs[i].rs2;
      #1;
      check($sformatf("row%0d a_ready", i), {31'b0, a_ready}, {31'b0, vecs[i].eARdy});
      check($sformatf("row%0d b_ready", i), {31'b0, b_ready}, {31'b0, vecs[i].eBRdy});
      check($sformatf("row%0d RegWrite", i), {31'b0, RegWrite}, {31'b0, vecs[i].eRW});
      check($sformatf("row%0d WriteRegister", i), {27'b0, WriteRegister}, {27'b0, vecs[i].eWR});
      check($sformatf("row%0d WriteData", i), WriteData, vecs[i].eWD);
      check($sformatf("row%0d hazard", i), {31'b0, hazard}, {31'b0, vecs[i].eHz});
      check($sformatf("row%0d both ready", i), {31'b0, a_ready & b_ready}, 32'h0);
      check($sformatf("row%0d fixed a_ready", i), {31'b0, p1ARdy}, {31'b0, vecs[i].aV});
      check($sformatf("row%0d fixed b_ready", i), {31'b0, p1BRdy},
            {31'b0, vecs[i].bV & ~vecs[i].aV});
    end

    // Reset in the middle of a write; pointer had moved to B before reset.
    @(negedge clk);
    idle();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h55;
    #1 check("midrst a_ready", {31'b0, a_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("midrst RegWrite before", {31'b0, RegWrite}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst RegWrite", {31'b0, RegWrite}, 32'h0);
    check("midrst WriteRegister", {27'b0, WriteRegister}, 32'h0);
    check("midrst WriteData", WriteData, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h44;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h66;
    #1;
    check("postrst a_ready", {31'b0, a_ready}, 32'h1);
    check("postrst b_ready", {31'b0, b_ready}, 32'h0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("postrst b_ready next", {31'b0, b_ready}, 32'h1);
    check("postrst WriteRegister", {27'b0, WriteRegister}, 32'h4);
    @(negedge clk);
    idle();
    @(negedge clk);

    // Issue to rd=9 and probe it from decode.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd9; chk_rs1 = 5'd9;
    #1 check("sb issue same cycle hazard", {31'b0, hazard}, 32'h0);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
`ifdef RF_SCOREBOARD_EN
    check("sb busy hazard", {31'b0, hazard}, 32'h1);
    @(negedge clk);
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    #1;
    check("sb b_ready", {31'b0, b_ready}, 32'h1);
    check("sb hazard at clear", {31'b0, hazard}, 32'h1);
    @(negedge clk);
    b_valid = 1'b0;
    #1 check("sb pending hazard", {31'b0, hazard}, 32'h1);
    @(negedge clk);
    #1 check("sb hazard released", {31'b0, hazard}, 32'h0);
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd9;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9A;
    #1 check("sb same-edge b_ready", {31'b0, b_ready}, 32'h1);
    @(negedge clk);
    iss_valid = 1'b0; b_valid = 1'b0;
    #1 check("sb same-edge hazard", {31'b0, hazard}, 32'h1);
    @(negedge clk);
    #1;
    check("sb same-edge RegWrite", {31'b0, RegWrite}, 32'h0);
    check("sb stays busy", {31'b0, hazard}, 32'h1);
`else
    check("no-sb issue ignored", {31'b0, hazard}, 32'h0);
    @(negedge clk);
    #1 check("no-sb still clear", {31'b0, hazard}, 32'h0);
`endif

    @(negedge clk);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
